route_comp_adaptive: RTL and testbench
======================================

// Module: route_comp_adaptive
// PURPOSE
//  Parametrised next-generation route-computation stage for the 3D-torus router input port.
//  Computes the output direction for head/single flits under DOR-XYZ or minimal-adaptive routing.
//  Locks that direction for the packet, updates the dateline VC class and the priority field,
//  and presents the flit through a one-deep valid/ready output register feeding VC/switch alloc.
// PARAMETERS
//  CUR_X / CUR_Y / CUR_Z   0      coordinates of this router
//  XSIZE / YSIZE / ZSIZE   4      torus extent per dimension (>=2)
//  ROUTE_MODE              0      0 = DOR-XYZ; 1 = minimal adaptive, congestion-aware
//  PRIO_MODE               0      0 = farthest-first (hop count decremented); 1 = oldest-first (pass-through)
// PORTS
//  clk        in   1          clock
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          upstream flit valid
//  in_ready   out  1          stage can accept: ~out_valid | out_ready
//  in_flit    in   FLIT_SIZE  flit, router_pkg layout
//  dir_in     in   3          arrival port, DIR_* encoding; DIR_INJECT for local injection
//  cong       in   6          per-output busy hint, index = DIR_XPOS..DIR_ZNEG; 1 = congested
//  out_valid  out  1          registered flit valid
//  out_ready  in   1          downstream accepts
//  out_flit   out  FLIT_SIZE  flit with VC class and priority field rewritten
//  out_dir    out  3          route of the current packet, held from head to tail
//  eject_en   out  1          out_valid && out_dir == DIR_EJECT
//  pkt_open   out  1          head accepted, tail not yet accepted
//  proto_err  out  1          sticky flag: body/tail without open packet, or head while packet open
// BEHAVIOUR
//  - Reset values: out_valid = 0, out_flit = 0, out_dir = DIR_EJECT, pkt_open = 0, proto_err = 0.
//    Reset mid-packet discards all state; the next flit must be a head.
//  - Transfer
//    - Input transfers on in_valid & in_ready; output transfers on out_valid & out_ready. Latency is 1 cycle.
//    - Full throughput with out_ready held high. No flit is dropped or duplicated under any stall pattern.
//    - out_flit and out_dir stay stable while out_valid & ~out_ready.
//  - Productive direction per dimension, X shown (Y and Z identical)
//    - d = (dst_x - CUR_X) mod XSIZE.
//    - d = 0: resolved. 0 < d <= XSIZE/2: XPOS. Otherwise: XNEG. A tie at exactly half goes positive.
//  - DOR (ROUTE_MODE 0): first unresolved dimension in order x, y, z. If all are resolved: DIR_EJECT.
//  - Adaptive (ROUTE_MODE 1), candidate rules
//    - Candidates are the productive dirs. YNEG is excluded while x is unresolved.
//    - ZNEG is excluded while x or y is unresolved. These rules enforce the six forbidden turns by construction.
//    - Pick the first non-congested candidate in order x, y, z.
//    - If all candidates are congested, pick the first candidate. If there are no candidates: DIR_EJECT.
//  - Route lock
//    - A head/single sets out_dir. Body/tail reuse the locked dir.
//    - pkt_open: head sets it, tail clears it. Single leaves it clear.
//  - Protocol errors
//    - A body/tail while ~pkt_open sets proto_err and is forwarded with the last out_dir.
//    - A head while pkt_open sets proto_err. The new head takes over.
//  - VC class (head/single only; body/tail copy the header bit unchanged)
//    - Dimension change or injection: class 0.
//    - Same dimension across the wrap link (XPOS at CUR_X = XSIZE-1, XNEG at CUR_X = 0, and likewise for Y/Z): class 1.
//    - Otherwise the class is preserved.
//  - Priority field (CMP_LEN bits)
//    - PRIO_MODE 0: head/single decrement it, saturating at 0.
//    - PRIO_MODE 1, and all body/tail: unchanged.
//  - Ejection: DIR_EJECT packets use the same path; downstream selects on eject_en.
// STRUCTURE
//  - router_pkg holds the flit type codes (HEAD/BODY/TAIL/SINGLE_FLIT) and the field positions/widths.
//    Field positions/widths: VC_CLASS_POS, DST_*POS, XW/YW/ZW, CMP_POS, CMP_LEN.
//  - router_pkg also holds the DIR_* constants (XPOS..ZNEG, EJECT, INJECT) and FLIT_SIZE.
//  - Sub-module route_sel: combinational productive-dir and candidate pick, parametrised by coords, sizes and mode.
//  - Top level holds the output register, route lock, VC/priority rewrite and error flag.
// TESTING (4x4x4, CUR=(1,1,1) unless noted)
//  1 DOR, inject single to (3,1,1), prio 5 -> out_dir XPOS, class 0, prio 4, out_valid 1 cycle later.
//  2 CUR_X=3, dir_in=XNEG, head to (1,1,1) -> XPOS wrap hop, class 1. Same at CUR_X=2 -> class preserved.
//  3 Adaptive, head to (2,2,1):
//    cong=XPOS -> YPOS; cong=XPOS|YPOS -> XPOS.
//    Head to (1,0,0) with x resolved -> YNEG allowed; to (2,1,0) -> ZNEG never chosen.
//  4 Head, 2 bodies, tail; out_ready low on cycles 2-3 -> in_ready low there, 4 flits out in order, same out_dir, pkt_open falls after tail.
//  5 Head to (1,1,1) -> out_dir EJECT, eject_en on all 4 flits. Body without head -> proto_err = 1, sticky.
//  6 rst asserted mid-packet (async, between edges) -> out_valid, pkt_open drop immediately; next head routes normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared flit layout, flit type codes and port-direction encoding for the torus router.
// No logic of its own; the two helpers are pure combinational functions.
// Backpressure: not applicable.
package router_pkg;

    localparam int FLIT_SIZE    = 32;

    // Flit type field
    localparam int TYPE_POS     = 0;
    localparam int TYPE_W       = 2;
    localparam logic [1:0] HEAD        = 2'd0;
    localparam logic [1:0] BODY        = 2'd1;
    localparam logic [1:0] TAIL        = 2'd2;
    localparam logic [1:0] SINGLE_FLIT = 2'd3;

    // Header fields
    localparam int VC_CLASS_POS = 2;
    localparam int XW           = 3;
    localparam int YW           = 3;
    localparam int ZW           = 3;
    localparam int DST_X_POS    = 3;
    localparam int DST_Y_POS    = DST_X_POS + XW;
    localparam int DST_Z_POS    = DST_Y_POS + YW;
    localparam int CMP_POS      = DST_Z_POS + ZW;
    localparam int CMP_LEN      = 4;

    // Port directions; dir[2:1] is the dimension (3 = local port)
    localparam logic [2:0] DIR_XPOS   = 3'd0;
    localparam logic [2:0] DIR_XNEG   = 3'd1;
    localparam logic [2:0] DIR_YPOS   = 3'd2;
    localparam logic [2:0] DIR_YNEG   = 3'd3;
    localparam logic [2:0] DIR_ZPOS   = 3'd4;
    localparam logic [2:0] DIR_ZNEG   = 3'd5;
    localparam logic [2:0] DIR_EJECT  = 3'd6;
    localparam logic [2:0] DIR_INJECT = 3'd7;

    // Productive direction in one dimension: {neg, pos}; 00 = already resolved.
    // Ties at exactly half the ring go positive.
    function automatic logic [1:0] prod_dir(input logic [2:0] dst, input int cur, input int size);
        logic [3:0] d;
        logic [3:0] sz;
        logic [3:0] cu;
        logic [1:0] res;
        sz = 4'(size);
        cu = 4'(cur);
        d  = {1'b0, dst} + sz - cu;
        if (d >= sz) begin
            d = d - sz;
        end
        if (d == 4'd0) begin
            res = 2'b00;
        end else if ({d, 1'b0} <= {1'b0, sz}) begin
            res = 2'b01;
        end else begin
            res = 2'b10;
        end
        return res;
    endfunction

    // Lowest set bit of a XPOS..ZNEG mask as a direction; EJECT when empty.
    function automatic logic [2:0] first_dir(input logic [5:0] mask);
        logic [2:0] res;
        res = DIR_EJECT;
        for (int i = 5; i >= 0; i--) begin
            if (mask[i]) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/route_sel.sv
// Route selection: productive directions per dimension, then DOR or minimal-adaptive pick.
// Latency: purely combinational.
// Backpressure: none; result is sampled by the parent only on an input transfer.
module route_sel
    import router_pkg::*;
#(
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0,
    parameter int CUR_Z      = 0,
    parameter int XSIZE      = 4,
    parameter int YSIZE      = 4,
    parameter int ZSIZE      = 4,
    parameter int ROUTE_MODE = 0
) (
    input  logic [XW-1:0] dst_x,
    input  logic [YW-1:0] dst_y,
    input  logic [ZW-1:0] dst_z,
    input  logic [5:0]    cong,
    output logic [2:0]    dir
);

    logic [1:0] px;
    logic [1:0] py;
    logic [1:0] pz;
    logic [5:0] cand;
    logic [5:0] free;

    assign px = prod_dir(dst_x, CUR_X, XSIZE);
    assign py = prod_dir(dst_y, CUR_Y, YSIZE);
    assign pz = prod_dir(dst_z, CUR_Z, ZSIZE);

    // Candidate mask in XPOS..ZNEG bit order, then the pick for the selected mode
    always_comb begin
        cand = {pz, py, px};
        free = 6'd0;
        dir  = DIR_EJECT;
        if (ROUTE_MODE == 0) begin
            // At most one bit per dimension, so the lowest bit is the first unresolved dim
            dir = first_dir(cand);
        end else begin
            // Removing these turns keeps the channel dependency graph acyclic
            cand[DIR_YNEG] = cand[DIR_YNEG] & ~(|px);
            cand[DIR_ZNEG] = cand[DIR_ZNEG] & ~(|px) & ~(|py);
            free = cand & ~cong;
            if (|free) begin
                dir = first_dir(free);
            end else begin
                dir = first_dir(cand);
            end
        end
    end

endmodule

// File: rtl/route_comp_adaptive.sv
// Route computation stage: routes heads, locks the route per packet, rewrites VC class and priority.
// Latency: 1 cycle through a one-deep output register; full throughput when out_ready stays high.
// Backpressure: in_ready = ~out_valid | out_ready; output held stable while stalled.
module route_comp_adaptive
    import router_pkg::*;
#(
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0,
    parameter int CUR_Z      = 0,
    parameter int XSIZE      = 4,
    parameter int YSIZE      = 4,
    parameter int ZSIZE      = 4,
    parameter int ROUTE_MODE = 0,
    parameter int PRIO_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLIT_SIZE-1:0] in_flit,
    input  logic [2:0]           dir_in,
    input  logic [5:0]           cong,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLIT_SIZE-1:0] out_flit,
    output logic [2:0]           out_dir,
    output logic                 eject_en,
    output logic                 pkt_open,
    output logic                 proto_err
);

    logic [1:0]           in_type;
    logic                 is_head;
    logic                 is_tail;
    logic                 accept;
    logic [2:0]           route_dir;
    logic                 wrap_hop;
    logic                 nxt_class;
    logic [CMP_LEN-1:0]   prio_in;
    logic [CMP_LEN-1:0]   prio_nxt;
    logic [FLIT_SIZE-1:0] nxt_flit;

    assign in_type  = in_flit[TYPE_POS +: TYPE_W];
    assign is_head  = (in_type == HEAD) || (in_type == SINGLE_FLIT);
    assign is_tail  = (in_type == TAIL);
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign eject_en = out_valid && (out_dir == DIR_EJECT);
    assign prio_in  = in_flit[CMP_POS +: CMP_LEN];

    route_sel #(
        .CUR_X      (CUR_X),
        .CUR_Y      (CUR_Y),
        .CUR_Z      (CUR_Z),
        .XSIZE      (XSIZE),
        .YSIZE      (YSIZE),
        .ZSIZE      (ZSIZE),
        .ROUTE_MODE (ROUTE_MODE)
    ) u_route_sel (
        .dst_x (in_flit[DST_X_POS +: XW]),
        .dst_y (in_flit[DST_Y_POS +: YW]),
        .dst_z (in_flit[DST_Z_POS +: ZW]),
        .cong  (cong),
        .dir   (route_dir)
    );

    // Dateline detection: the chosen hop leaves on this router's wrap-around link
    always_comb begin
        case (route_dir)
            DIR_XPOS: wrap_hop = (CUR_X == XSIZE - 1);
            DIR_XNEG: wrap_hop = (CUR_X == 0);
            DIR_YPOS: wrap_hop = (CUR_Y == YSIZE - 1);
            DIR_YNEG: wrap_hop = (CUR_Y == 0);
            DIR_ZPOS: wrap_hop = (CUR_Z == ZSIZE - 1);
            DIR_ZNEG: wrap_hop = (CUR_Z == 0);
            default:  wrap_hop = 1'b0;
        endcase
    end

    // Header rewrite for head/single; body/tail pass through untouched
    always_comb begin
        nxt_flit = in_flit;
        if (dir_in == DIR_INJECT || route_dir[2:1] != dir_in[2:1]) begin
            nxt_class = 1'b0;
        end else if (wrap_hop) begin
            nxt_class = 1'b1;
        end else begin
            nxt_class = in_flit[VC_CLASS_POS];
        end
        if (PRIO_MODE == 0 && prio_in != '0) begin
            prio_nxt = prio_in - CMP_LEN'(1);
        end else begin
            prio_nxt = prio_in;
        end
        if (is_head) begin
            nxt_flit[VC_CLASS_POS]        = nxt_class;
            nxt_flit[CMP_POS +: CMP_LEN]  = prio_nxt;
        end
    end

    // Output register and route lock; a new route only loads when the flit register does
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_dir   <= DIR_EJECT;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_flit  <= nxt_flit;
            if (is_head) begin
                out_dir <= route_dir;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Packet framing tracker and sticky protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_open  <= 1'b0;
            proto_err <= 1'b0;
        end else if (accept) begin
            if (is_head) begin
                pkt_open <= (in_type == HEAD);
                if (pkt_open) begin
                    proto_err <= 1'b1;
                end
            end else begin
                if (!pkt_open) begin
                    proto_err <= 1'b1;
                end
                if (is_tail) begin
                    pkt_open <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_route_comp_adaptive.sv
module tb_route_comp_adaptive;
    import router_pkg::*;

    localparam int NDUT = 4;
    localparam int SZ   = 4;
    localparam int CX [NDUT] = '{1, 1, 3, 2};
    localparam int CY [NDUT] = '{1, 1, 1, 1};
    localparam int CZ [NDUT] = '{1, 1, 1, 0};
    localparam int RM [NDUT] = '{0, 1, 0, 1};
    localparam int PM [NDUT] = '{0, 1, 0, 0};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [FLIT_SIZE-1:0] in_flit;
    logic [2:0]           dir_in;
    logic [5:0]           cong;
    logic                 out_ready;

    logic                 o_rdy  [NDUT];
    logic                 o_vld  [NDUT];
    logic [FLIT_SIZE-1:0] o_flit [NDUT];
    logic [2:0]           o_dir  [NDUT];
    logic                 o_ej   [NDUT];
    logic                 o_open [NDUT];
    logic                 o_err  [NDUT];

    always #5 clk = ~clk;

    route_comp_adaptive #(.CUR_X(CX[0]), .CUR_Y(CY[0]), .CUR_Z(CZ[0]), .XSIZE(SZ), .YSIZE(SZ), .ZSIZE(SZ),
        .ROUTE_MODE(RM[0]), .PRIO_MODE(PM[0])) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[0]), .in_flit(in_flit), .dir_in(dir_in),
        .cong(cong), .out_valid(o_vld[0]), .out_ready(out_ready), .out_flit(o_flit[0]), .out_dir(o_dir[0]),
        .eject_en(o_ej[0]), .pkt_open(o_open[0]), .proto_err(o_err[0]));
    route_comp_adaptive #(.CUR_X(CX[1]), .CUR_Y(CY[1]), .CUR_Z(CZ[1]), .XSIZE(SZ), .YSIZE(SZ), .ZSIZE(SZ),
        .ROUTE_MODE(RM[1]), .PRIO_MODE(PM[1])) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[1]), .in_flit(in_flit), .dir_in(dir_in),
        .cong(cong), .out_valid(o_vld[1]), .out_ready(out_ready), .out_flit(o_flit[1]), .out_dir(o_dir[1]),
        .eject_en(o_ej[1]), .pkt_open(o_open[1]), .proto_err(o_err[1]));
    route_comp_adaptive #(.CUR_X(CX[2]), .CUR_Y(CY[2]), .CUR_Z(CZ[2]), .XSIZE(SZ), .YSIZE(SZ), .ZSIZE(SZ),
        .ROUTE_MODE(RM[2]), .PRIO_MODE(PM[2])) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[2]), .in_flit(in_flit), .dir_in(dir_in),
        .cong(cong), .out_valid(o_vld[2]), .out_ready(out_ready), .out_flit(o_flit[2]), .out_dir(o_dir[2]),
        .eject_en(o_ej[2]), .pkt_open(o_open[2]), .proto_err(o_err[2]));
    route_comp_adaptive #(.CUR_X(CX[3]), .CUR_Y(CY[3]), .CUR_Z(CZ[3]), .XSIZE(SZ), .YSIZE(SZ), .ZSIZE(SZ),
        .ROUTE_MODE(RM[3]), .PRIO_MODE(PM[3])) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[3]), .in_flit(in_flit), .dir_in(dir_in),
        .cong(cong), .out_valid(o_vld[3]), .out_ready(out_ready), .out_flit(o_flit[3]), .out_dir(o_dir[3]),
        .eject_en(o_ej[3]), .pkt_open(o_open[3]), .proto_err(o_err[3]));

    // Reference model: flits accepted but not yet taken downstream, one entry per transfer
    typedef struct packed {
        logic [NDUT-1:0][FLIT_SIZE-1:0] f;
        logic [NDUT-1:0][2:0]           d;
    } ent_t;

    ent_t       q[$];
    logic       m_open [NDUT];
    logic       m_err  [NDUT];
    logic [2:0] m_lock [NDUT];
    int         errors = 0;
    int         checks = 0;
    logic       last_acc;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Shortest signed hop offset on a ring; exactly half the ring counts as positive
    function automatic int ring_off(input int dst, input int cur);
        int d;
        d = ((dst - cur) % SZ + SZ) % SZ;
        if (d == 0) return 0;
        if (2 * d <= SZ) return d;
        return d - SZ;
    endfunction

    function automatic logic [2:0] m_route(input int k, input int dx, input int dy, input int dz, input logic [5:0] cg);
        int         o [3];
        logic [2:0] pd [3];
        bit         ok [3];
        bit         al [3];
        bit         found;
        logic [2:0] res;
        o[0] = ring_off(dx, CX[k]);
        o[1] = ring_off(dy, CY[k]);
        o[2] = ring_off(dz, CZ[k]);
        for (int i = 0; i < 3; i++) begin
            pd[i] = 3'(2 * i + ((o[i] < 0) ? 1 : 0));
            ok[i] = (o[i] != 0);
        end
        al[0] = ok[0];
        al[1] = ok[1] && !(o[1] < 0 && ok[0]);
        al[2] = ok[2] && !(o[2] < 0 && (ok[0] || ok[1]));
        res   = DIR_EJECT;
        found = 0;
        if (RM[k] == 0) begin
            for (int i = 0; i < 3; i++) if (!found && ok[i]) begin res = pd[i]; found = 1; end
        end else begin
            for (int i = 0; i < 3; i++) if (!found && al[i] && !cg[pd[i]]) begin res = pd[i]; found = 1; end
            for (int i = 0; i < 3; i++) if (!found && al[i]) begin res = pd[i]; found = 1; end
        end
        return res;
    endfunction

    // True when a hop from this router in direction d falls off the end of the ring
    function automatic bit m_wrap(input int k, input logic [2:0] d);
        int cur;
        int nxt;
        if (d == DIR_EJECT || d == DIR_INJECT) return 0;
        cur = (d[2:1] == 2'd0) ? CX[k] : (d[2:1] == 2'd1) ? CY[k] : CZ[k];
        nxt = d[0] ? cur - 1 : cur + 1;
        return (nxt < 0) || (nxt >= SZ);
    endfunction

    task automatic m_reset();
        q.delete();
        for (int k = 0; k < NDUT; k++) begin
            m_open[k] = 1'b0;
            m_err[k]  = 1'b0;
            m_lock[k] = DIR_EJECT;
        end
    endtask

    task automatic m_accept(input logic [FLIT_SIZE-1:0] f, input logic [2:0] di, input logic [5:0] cg);
        ent_t                 e;
        logic [1:0]           t;
        logic [2:0]           d;
        logic [FLIT_SIZE-1:0] o;
        int                   pr;
        t = f[TYPE_POS +: TYPE_W];
        for (int k = 0; k < NDUT; k++) begin
            o = f;
            if (t == HEAD || t == SINGLE_FLIT) begin
                d = m_route(k, int'(f[DST_X_POS +: XW]), int'(f[DST_Y_POS +: YW]), int'(f[DST_Z_POS +: ZW]), cg);
                if (m_open[k]) m_err[k] = 1'b1;
                m_open[k] = (t == HEAD);
                m_lock[k] = d;
                if (di == DIR_INJECT || (int'(d) / 2) != (int'(di) / 2)) o[VC_CLASS_POS] = 1'b0;
                else if (m_wrap(k, d)) o[VC_CLASS_POS] = 1'b1;
                pr = int'(f[CMP_POS +: CMP_LEN]);
                if (PM[k] == 0 && pr > 0) o[CMP_POS +: CMP_LEN] = CMP_LEN'(pr - 1);
            end else begin
                if (!m_open[k]) m_err[k] = 1'b1;
                if (t == TAIL) m_open[k] = 1'b0;
                d = m_lock[k];
            end
            e.f[k] = o;
            e.d[k] = d;
        end
        q.push_back(e);
    endtask

    task automatic check_all();
        ent_t h;
        for (int k = 0; k < NDUT; k++) begin
            chk("in_ready", k, 32'(o_rdy[k]), 32'((q.size() == 0) || out_ready));
            chk("out_valid", k, 32'(o_vld[k]), 32'(q.size() != 0));
            if (q.size() != 0) begin
                h = q[0];
                chk("out_flit", k, o_flit[k], h.f[k]);
                chk("out_dir", k, 32'(o_dir[k]), 32'(h.d[k]));
                chk("eject_en", k, 32'(o_ej[k]), 32'(h.d[k] == DIR_EJECT));
            end else begin
                chk("eject_en", k, 32'(o_ej[k]), 32'd0);
            end
            chk("pkt_open", k, 32'(o_open[k]), 32'(m_open[k]));
            chk("proto_err", k, 32'(o_err[k]), 32'(m_err[k]));
        end
    endtask

    // One clock: drive after the falling edge, check, then advance the model to the next rising edge
    task automatic step(input logic v, input logic [FLIT_SIZE-1:0] f, input logic [2:0] di,
                        input logic [5:0] cg, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_flit   = f;
        dir_in    = di;
        cong      = cg;
        out_ready = ordy;
        #1;
        check_all();
        last_acc = v && ((q.size() == 0) || ordy);
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (last_acc) m_accept(f, di, cg);
    endtask

    function automatic logic [FLIT_SIZE-1:0] mk(input logic [1:0] t, input logic vc,
                                                input int dx, input int dy, input int dz, input int pr);
        logic [FLIT_SIZE-1:0] f;
        f = FLIT_SIZE'($urandom);
        f[TYPE_POS +: TYPE_W]  = t;
        f[VC_CLASS_POS]        = vc;
        f[DST_X_POS +: XW]     = XW'(dx);
        f[DST_Y_POS +: YW]     = YW'(dy);
        f[DST_Z_POS +: ZW]     = ZW'(dz);
        f[CMP_POS +: CMP_LEN]  = CMP_LEN'(pr);
        return f;
    endfunction

    logic [FLIT_SIZE-1:0] pkt [4];
    int                   idx;
    int                   r;
    logic [1:0]           t;
    logic [2:0]           di;

    initial begin
        in_valid  = 1'b0;
        in_flit   = '0;
        dir_in    = DIR_INJECT;
        cong      = '0;
        out_ready = 1'b1;
        rst       = 1'b0;
        last_acc  = 1'b0;
        #2 rst = 1'b1;
        #6;
        m_reset();
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_out_valid", k, 32'(o_vld[k]), 32'd0);
            chk("rst_out_flit", k, o_flit[k], 32'd0);
            chk("rst_out_dir", k, 32'(o_dir[k]), 32'(DIR_EJECT));
            chk("rst_pkt_open", k, 32'(o_open[k]), 32'd0);
            chk("rst_proto_err", k, 32'(o_err[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Injected single to (3,1,1), prio 5: XPOS, class 0, prio decremented one cycle later
        step(1, mk(SINGLE_FLIT, 1'b1, 3, 1, 1, 5), DIR_INJECT, 6'd0, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t1_dir", 0, 32'(o_dir[0]), 32'(DIR_XPOS));
        chk("t1_class", 0, 32'(o_flit[0][VC_CLASS_POS]), 32'd0);
        chk("t1_prio", 0, 32'(o_flit[0][CMP_POS +: CMP_LEN]), 32'd4);
        chk("t1_prio_oldest_first", 1, 32'(o_flit[1][CMP_POS +: CMP_LEN]), 32'd5);

        // Arriving on XNEG to (1,1,1): wrap hop at x=3 sets class 1, x=2 keeps class
        step(1, mk(SINGLE_FLIT, 1'b0, 1, 1, 1, 0), DIR_XNEG, 6'd0, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t2_wrap_dir", 2, 32'(o_dir[2]), 32'(DIR_XPOS));
        chk("t2_wrap_class", 2, 32'(o_flit[2][VC_CLASS_POS]), 32'd1);
        chk("t2_keep_dir", 3, 32'(o_dir[3]), 32'(DIR_XNEG));
        chk("t2_keep_class", 3, 32'(o_flit[3][VC_CLASS_POS]), 32'd0);
        chk("t2_prio_sat", 0, 32'(o_flit[0][CMP_POS +: CMP_LEN]), 32'd0);
        step(1, mk(SINGLE_FLIT, 1'b1, 1, 1, 1, 3), DIR_XNEG, 6'd0, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t2_keep_class1", 3, 32'(o_flit[3][VC_CLASS_POS]), 32'd1);

        // Adaptive choices at (1,1,1)
        step(1, mk(SINGLE_FLIT, 1'b0, 2, 2, 1, 2), DIR_INJECT, 6'b000001, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t3_avoid_xpos", 1, 32'(o_dir[1]), 32'(DIR_YPOS));
        step(1, mk(SINGLE_FLIT, 1'b0, 2, 2, 1, 2), DIR_INJECT, 6'b000101, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t3_all_busy", 1, 32'(o_dir[1]), 32'(DIR_XPOS));
        step(1, mk(SINGLE_FLIT, 1'b0, 1, 0, 0, 2), DIR_INJECT, 6'b001000, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t3_yneg_ok", 1, 32'(o_dir[1]), 32'(DIR_YNEG));
        step(1, mk(SINGLE_FLIT, 1'b0, 2, 1, 0, 2), DIR_INJECT, 6'b000001, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t3_no_zneg", 1, 32'(o_dir[1]), 32'(DIR_XPOS));

        // Four-flit packet with downstream stalled for two cycles
        pkt[0] = mk(HEAD, 1'b0, 1, 3, 1, 9);
        pkt[1] = mk(BODY, 1'b0, 0, 0, 0, 1);
        pkt[2] = mk(BODY, 1'b1, 2, 2, 2, 7);
        pkt[3] = mk(TAIL, 1'b0, 3, 0, 3, 0);
        idx = 0;
        for (int c = 1; c < 20 && idx < 4; c++) begin
            step(1, pkt[idx], DIR_INJECT, 6'd0, !(c == 2 || c == 3));
            if (c == 2 || c == 3) chk("t4_stall_in_ready", 0, 32'(o_rdy[0]), 32'd0);
            if (c == 3) chk("t4_pkt_open_mid", 0, 32'(o_open[0]), 32'd1);
            if (last_acc) idx++;
        end
        step(0, '0, DIR_INJECT, 6'd0, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t4_pkt_open_after", 0, 32'(o_open[0]), 32'd0);

        // Packet addressed to this router ejects; then an orphan body
        pkt[0] = mk(HEAD, 1'b0, 1, 1, 1, 4);
        pkt[1] = mk(BODY, 1'b0, 2, 0, 3, 4);
        pkt[2] = mk(BODY, 1'b0, 0, 3, 2, 4);
        pkt[3] = mk(TAIL, 1'b0, 3, 3, 0, 4);
        for (int i = 0; i < 4; i++) begin
            step(1, pkt[i], DIR_YPOS, 6'd0, 1);
            if (i > 0) chk("t5_eject_en", 0, 32'(o_ej[0]), 32'd1);
        end
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t5_eject_tail", 0, 32'(o_ej[0]), 32'd1);
        step(1, mk(BODY, 1'b0, 3, 3, 3, 1), DIR_INJECT, 6'd0, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t5_proto_err", 0, 32'(o_err[0]), 32'd1);
        step(1, mk(SINGLE_FLIT, 1'b0, 2, 1, 1, 1), DIR_INJECT, 6'd0, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);
        chk("t5_proto_err_sticky", 0, 32'(o_err[0]), 32'd1);

        // Asynchronous reset in the middle of a packet
        step(1, mk(HEAD, 1'b0, 3, 1, 1, 6), DIR_INJECT, 6'd0, 1);
        step(1, mk(BODY, 1'b0, 0, 0, 0, 6), DIR_INJECT, 6'd0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("t6_rst_out_valid", k, 32'(o_vld[k]), 32'd0);
            chk("t6_rst_pkt_open", k, 32'(o_open[k]), 32'd0);
            chk("t6_rst_proto_err", k, 32'(o_err[k]), 32'd0);
        end
        m_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1, mk(HEAD, 1'b0, 3, 1, 1, 6), DIR_INJECT, 6'd0, 1);
        step(1, mk(TAIL, 1'b0, 0, 0, 0, 6), DIR_INJECT, 6'd0, 1);
        chk("t6_head_after_rst", 0, 32'(o_dir[0]), 32'(DIR_XPOS));
        chk("t6_open_after_rst", 0, 32'(o_open[0]), 32'd1);
        step(0, '0, DIR_INJECT, 6'd0, 1);

        // Randomised traffic, mostly well-formed packets with occasional framing errors
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(99));
            if (m_open[0]) t = (r < 65) ? BODY : (r < 93) ? TAIL : HEAD;
            else           t = (r < 45) ? HEAD : (r < 92) ? SINGLE_FLIT : (r < 96) ? BODY : TAIL;
            r  = int'($urandom_range(6));
            di = (r == 6) ? DIR_INJECT : 3'(r);
            step($urandom_range(3) != 0,
                 mk(t, 1'($urandom_range(1)), int'($urandom_range(SZ - 1)), int'($urandom_range(SZ - 1)),
                    int'($urandom_range(SZ - 1)), int'($urandom_range(15))),
                 di, 6'($urandom), $urandom_range(3) != 0);
        end
        step(0, '0, DIR_INJECT, 6'd0, 1);
        step(0, '0, DIR_INJECT, 6'd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
